fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter AB, default 11, program-memory address width.
REQ-002 Parameter DB, default 16, instruction width.
REQ-003 Parameter OPW, default 5, opcode width; opcode = Data_in[DB-1:DB-OPW].
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  level; begins program run from address 0 when IDLE or HALTED.
REQ-007 stall  input  1  datapath busy; holds current issued instruction.
REQ-008 pc_load  input  1  branch request, sampled only on ISSUE exit.
REQ-009 pc_target  input  AB  branch destination address.
REQ-010 Data_in  input  DB  instruction word from program memory; memory samples Addr on falling clk edge.
REQ-011 Addr  output  AB  registered program counter driven to program memory.
REQ-012 Instr  output  DB  registered copy of last fetched word.
REQ-013 instr_valid  output  1  Instr is issued to the datapath this cycle.
REQ-014 halted  output  1  program has reached a HALT opcode.
REQ-015 cycle_count  output  16  clock cycles spent running (FETCH + ISSUE).

Function
REQ-016 FSM states: IDLE, FETCH, ISSUE, HALTED; one-hot or binary is implementer's choice.
REQ-017 IDLE: Addr held at 0; start=1 -> FETCH, cycle_count cleared to 0.
REQ-018 FETCH: lasts exactly one cycle; memory word for Addr is valid at the next rising edge via the falling-edge read.
REQ-019 FETCH exit, opcode != 0: Instr <= Data_in, Addr <= Addr+1 (mod 2^AB), -> ISSUE.
REQ-020 FETCH exit, opcode == 0 (HALT): Instr <= Data_in, Addr unchanged, -> HALTED; HALT word never issued.
REQ-021 ISSUE: instr_valid=1 for every ISSUE cycle; state, Addr, Instr held while stall=1.
REQ-022 ISSUE exit (stall=0): pc_load=1 -> Addr <= pc_target, else Addr unchanged; -> FETCH.
REQ-023 pc_load while stall=1 is ignored; only the value on the exit cycle counts.
REQ-024 instr_valid=0 in IDLE, FETCH, HALTED.
REQ-025 halted=1 in HALTED only; Addr holds the HALT address.
REQ-026 HALTED: start=1 -> Addr <= 0, cycle_count <= 0, halted cleared, -> FETCH next cycle.
REQ-027 start while FETCH or ISSUE is ignored.
REQ-028 cycle_count increments by 1 on every rising edge in FETCH or ISSUE (stall cycles included); saturates at 16'hFFFF; frozen in IDLE and HALTED.
REQ-029 Addr wrap: increment from 2^AB-1 yields 0, no flag.
REQ-030 Issue throughput with stall=0: one instruction per two cycles.

Reset
REQ-031 reset=0 asynchronously forces: state IDLE, Addr=0, Instr=0, instr_valid=0, halted=0, cycle_count=0.
REQ-032 reset asserted mid-FETCH/ISSUE aborts without issuing; after release, start required to run again.
REQ-033 Deassertion takes effect at first rising edge after reset=1; start sampled that edge.

Verification
REQ-034 Program 0x0801,0x1002,0x1803,0x2004,0x2805,0x3006,0x3807,0x0000 at 0..7, start pulse -> seven instr_valid pulses with those Instr values in order, halted=1, Addr=7, cycle_count=15.
REQ-035 Same program, stall=1 for 3 cycles during 2nd issue -> Instr=0x1002 held with instr_valid=1 for 4 cycles, final cycle_count=18.
REQ-036 pc_load=1, pc_target=5 on ISSUE exit of addr 1 -> next issued Instr=0x3006, then 0x3807, halt at 7.
REQ-037 From HALTED, start=1 -> restart at Addr=0, cycle_count=0, first issued Instr=0x0801.
REQ-038 reset=0 during ISSUE of addr 3 -> all outputs zero immediately; start after release re-issues from 0x0801.
REQ-039 AB=3, memory all non-HALT -> Addr sequence 0..7,0 wraps; cycle_count saturates at 0xFFFF on a long run.

Source files
------------

// File: rtl/fetch_controller.sv
// ----------------------------------------------------------------------------
// fetch_controller
//
// Purpose:
//   Sequences instruction fetch from a synchronous program memory and issues
//   one instruction at a time to a datapath. The memory samples Addr on the
//   falling clock edge, so the word for the current Addr is stable on Data_in
//   by the next rising edge. One fetch cycle plus at least one issue cycle
//   per instruction. An all-zero opcode is HALT: it is latched into Instr
//   but never issued.
//
// Ports:
//   clk          in   single clock, all state on rising edge
//   reset        in   asynchronous, active-low reset
//   start        in   level; begins a run from address 0 (IDLE or HALTED)
//   stall        in   datapath busy; holds the instruction being issued
//   pc_load      in   branch request, honoured only on the ISSUE exit cycle
//   pc_target    in   [AB]  branch destination
//   Data_in      in   [DB]  instruction word from program memory
//   Addr         out  [AB]  registered program counter
//   Instr        out  [DB]  registered copy of the last fetched word
//   instr_valid  out  Instr is issued to the datapath this cycle
//   halted       out  a HALT opcode has been reached
//   cycle_count  out  [16] running cycles (FETCH + ISSUE), saturating
// ----------------------------------------------------------------------------
module fetch_controller #(
    parameter int AB  = 11,
    parameter int DB  = 16,
    parameter int OPW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    input  logic          pc_load,
    input  logic [AB-1:0] pc_target,
    input  logic [DB-1:0] Data_in,
    output logic [AB-1:0] Addr,
    output logic [DB-1:0] Instr,
    output logic          instr_valid,
    output logic          halted,
    output logic [15:0]   cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    state_e        state_q;
    logic [AB-1:0] addr_q;
    logic [DB-1:0] instr_q;
    logic          valid_q;
    logic          halted_q;
    logic [15:0]   cnt_q;

    logic [AB-1:0] addr_inc_d;
    logic [15:0]   cnt_inc_d;
    logic          is_halt;

    // HALT is recognised purely by an all-zero opcode field.
    assign is_halt    = (Data_in[DB-1:DB-OPW] == '0);

    // Natural AB-bit wrap, no carry out.
    assign addr_inc_d = addr_q + AB'(1);

    // Saturating running-cycle counter.
    assign cnt_inc_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    // All outputs are registered; instr_valid and halted are set on the
    // transition into ISSUE / HALTED so they are true exactly in those states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_FETCH;
                        addr_q  <= '0;
                        cnt_q   <= '0;
                    end
                end

                ST_FETCH: begin
                    cnt_q   <= cnt_inc_d;
                    instr_q <= Data_in;
                    if (is_halt) begin
                        // Addr stays on the HALT word for observability.
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= ST_ISSUE;
                        addr_q  <= addr_inc_d;
                        valid_q <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    cnt_q <= cnt_inc_d;
                    // While stalled everything holds; pc_load is only looked
                    // at on the cycle the stall drops.
                    if (!stall) begin
                        state_q <= ST_FETCH;
                        valid_q <= 1'b0;
                        if (pc_load) begin
                            addr_q <= pc_target;
                        end
                    end
                end

                ST_HALTED: begin
                    if (start) begin
                        state_q  <= ST_FETCH;
                        addr_q   <= '0;
                        cnt_q    <= '0;
                        halted_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Addr        = addr_q;
    assign Instr       = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// ----------------------------------------------------------------------------
// tb_fetch_controller
//   Directed and randomized runs of fetch_controller against a program-level
//   reference: the expected issue sequence, branch effects, halt address and
//   cycle total are computed by walking the program memory, not by modelling
//   the state machine. A second instance with AB=3 runs freely to show address
//   wrap and counter saturation.
// ----------------------------------------------------------------------------
module tb_fetch_controller;

    localparam int AB    = 11;
    localparam int DB    = 16;
    localparam int MSIZE = 1 << AB;

    logic          clk;
    logic          reset, start, stall, pc_load;
    logic [AB-1:0] pc_target;
    logic [DB-1:0] Data_in;
    logic [AB-1:0] Addr;
    logic [DB-1:0] Instr;
    logic          instr_valid, halted;
    logic [15:0]   cycle_count;

    // Wrap / saturation instance
    logic          reset_w, start_w, stall_w, pc_load_w;
    logic [2:0]    pc_target_w;
    logic [DB-1:0] data_w;
    logic [2:0]    addr_w;
    logic [DB-1:0] instr_w;
    logic          valid_w, halted_w;
    logic [15:0]   cnt_w;

    fetch_controller #(.AB(AB), .DB(DB), .OPW(5)) u_dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .pc_load(pc_load), .pc_target(pc_target), .Data_in(Data_in),
        .Addr(Addr), .Instr(Instr), .instr_valid(instr_valid),
        .halted(halted), .cycle_count(cycle_count)
    );

    fetch_controller #(.AB(3), .DB(DB), .OPW(5)) u_wrap (
        .clk(clk), .reset(reset_w), .start(start_w), .stall(stall_w),
        .pc_load(pc_load_w), .pc_target(pc_target_w), .Data_in(data_w),
        .Addr(addr_w), .Instr(instr_w), .instr_valid(valid_w),
        .halted(halted_w), .cycle_count(cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memories: read on the falling edge
    logic [DB-1:0] mem  [0:MSIZE-1];
    logic [DB-1:0] mem3 [0:7];
    always @(negedge clk) begin
        Data_in = mem[Addr];
        data_w  = mem3[addr_w];
    end

    int n_cmp = 0;
    int n_err = 0;
    int ticks = 0;

    // Reference plan
    logic [DB-1:0] exp_word [0:63];
    int            exp_pc   [0:63];
    int            st [0:63];
    bit            br [0:63];
    int            tg [0:63];
    int            n_iss, halt_pc, exp_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ticks++;
    endtask

    task automatic clear_ctl();
        for (int i = 0; i < 64; i++) begin
            st[i] = 0; br[i] = 1'b0; tg[i] = 0;
        end
    endtask

    task automatic load_demo();
        logic [DB-1:0] prog [0:7];
        prog = '{16'h0801, 16'h1002, 16'h1803, 16'h2004,
                 16'h2805, 16'h3006, 16'h3807, 16'h0000};
        for (int a = 0; a < MSIZE; a++) mem[a] = DB'($urandom);
        for (int a = 0; a < 8; a++) mem[a] = prog[a];
    endtask

    // Random program: non-HALT words up to hpos, HALT at hpos
    task automatic load_random(input int hpos);
        logic [DB-1:0] w;
        for (int a = 0; a < MSIZE; a++) mem[a] = DB'($urandom);
        for (int a = 0; a < hpos; a++) begin
            w = DB'($urandom);
            if (w[15:11] == 5'd0) w[11] = 1'b1;
            mem[a] = w;
        end
        mem[hpos] = DB'($urandom) & 16'h07FF;
    endtask

    // Walk the program: each instruction costs one fetch cycle plus
    // (1 + stall) issue cycles; the final HALT costs one fetch cycle.
    task automatic plan(input bit rnd, input int hpos);
        int pc, sum_st;
        pc = 0; n_iss = 0; sum_st = 0;
        while (mem[pc][15:11] != 5'd0 && n_iss < 60) begin
            exp_word[n_iss] = mem[pc];
            exp_pc[n_iss]   = pc;
            if (rnd) begin
                st[n_iss] = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(3, 1));
                br[n_iss] = ($urandom_range(3, 0) == 0);
                tg[n_iss] = int'($urandom_range(hpos, pc + 1));
            end
            sum_st += st[n_iss];
            pc = br[n_iss] ? tg[n_iss] : (pc + 1) % MSIZE;
            n_iss++;
        end
        halt_pc = pc;
        exp_cyc = 2 * n_iss + 1 + sum_st;
    endtask

    // Execute the current plan; abort_pc >= 0 pulls reset while that
    // address is being issued.
    task automatic run(input int abort_pc);
        int cnt, nxt;
        start = 1'b1; tick(); start = 1'b0;
        stall = 1'b0; pc_load = 1'b0;
        cnt = 0;
        chk("start_addr", 32'(Addr), 0);
        chk("start_cnt", 32'(cycle_count), 0);
        chk("start_halted", 32'(halted), 0);
        chk("start_vld", 32'(instr_valid), 0);
        for (int i = 0; i < n_iss; i++) begin
            tick(); cnt++;
            chk("iss_vld", 32'(instr_valid), 1);
            chk("iss_instr", 32'(Instr), 32'(exp_word[i]));
            chk("iss_addr", 32'(Addr), 32'((exp_pc[i] + 1) % MSIZE));
            chk("iss_cnt", 32'(cycle_count), 32'(cnt));
            if (exp_pc[i] == abort_pc) begin
                #2 reset = 1'b0;
                #1;
                chk("rst_addr", 32'(Addr), 0);
                chk("rst_instr", 32'(Instr), 0);
                chk("rst_vld", 32'(instr_valid), 0);
                chk("rst_halted", 32'(halted), 0);
                chk("rst_cnt", 32'(cycle_count), 0);
                #1 reset = 1'b1;
                repeat (2) tick();
                chk("post_rst_vld", 32'(instr_valid), 0);
                chk("post_rst_addr", 32'(Addr), 0);
                chk("post_rst_cnt", 32'(cycle_count), 0);
                return;
            end
            for (int s = 0; s < st[i]; s++) begin
                stall = 1'b1;
                pc_load = 1'($urandom);
                pc_target = AB'($urandom);
                start = 1'($urandom);
                tick(); cnt++;
                start = 1'b0;
                chk("stl_vld", 32'(instr_valid), 1);
                chk("stl_instr", 32'(Instr), 32'(exp_word[i]));
                chk("stl_addr", 32'(Addr), 32'((exp_pc[i] + 1) % MSIZE));
            end
            stall = 1'b0;
            pc_load = br[i];
            pc_target = AB'(tg[i]);
            start = 1'($urandom);
            tick(); cnt++;
            start = 1'b0; pc_load = 1'b0;
            nxt = br[i] ? tg[i] : (exp_pc[i] + 1) % MSIZE;
            chk("fet_vld", 32'(instr_valid), 0);
            chk("fet_addr", 32'(Addr), 32'(nxt));
        end
        tick();
        chk("halt_flag", 32'(halted), 1);
        chk("halt_vld", 32'(instr_valid), 0);
        chk("halt_addr", 32'(Addr), 32'(halt_pc));
        chk("halt_instr", 32'(Instr), 32'(mem[halt_pc]));
        chk("halt_cnt", 32'(cycle_count), 32'(exp_cyc));
        repeat (3) tick();
        chk("hold_cnt", 32'(cycle_count), 32'(exp_cyc));
        chk("hold_halted", 32'(halted), 1);
    endtask

    initial begin
        int t0, hpos;
        reset = 1'b0; start = 1'b0; stall = 1'b0; pc_load = 1'b0; pc_target = '0;
        reset_w = 1'b0; start_w = 1'b0; stall_w = 1'b0; pc_load_w = 1'b0; pc_target_w = '0;
        for (int a = 0; a < 8; a++) begin
            mem3[a] = DB'($urandom);
            if (mem3[a][15:11] == 5'd0) mem3[a][12] = 1'b1;
        end
        load_demo();

        // Reset state
        #3;
        chk("reset_addr", 32'(Addr), 0);
        chk("reset_instr", 32'(Instr), 0);
        chk("reset_vld", 32'(instr_valid), 0);
        chk("reset_halted", 32'(halted), 0);
        chk("reset_cnt", 32'(cycle_count), 0);
        #1 reset = 1'b1; reset_w = 1'b1;
        repeat (2) tick();
        chk("idle_addr", 32'(Addr), 0);
        chk("idle_vld", 32'(instr_valid), 0);

        // AB=3 instance: free-running straight-line code wraps 7 -> 0
        start_w = 1'b1; tick(); start_w = 1'b0;
        t0 = ticks;
        chk("w_start_cnt", 32'(cnt_w), 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("w_addr", 32'(addr_w), 32'((k + 1) % 8));
            chk("w_instr", 32'(instr_w), 32'(mem3[k % 8]));
            chk("w_vld", 32'(valid_w), 1);
            tick();
            chk("w_fetch_vld", 32'(valid_w), 0);
        end
        chk("w_cnt40", 32'(cnt_w), 40);

        // Demo program straight through
        clear_ctl(); plan(1'b0, 7); run(-1);
        chk("demo_cnt15", 32'(cycle_count), 15);
        chk("demo_addr7", 32'(Addr), 7);

        // 3-cycle stall on the 2nd issue, restarting from HALTED
        clear_ctl(); st[1] = 3; plan(1'b0, 7); run(-1);
        chk("stall_cnt18", 32'(cycle_count), 18);

        // Branch from addr 1 to 5
        clear_ctl(); br[1] = 1'b1; tg[1] = 5; plan(1'b0, 7); run(-1);
        chk("br_instr_last", 32'(Instr), 0);
        chk("br_cnt", 32'(cycle_count), 9);

        // Reset while issuing addr 3, then a clean run from IDLE
        clear_ctl(); plan(1'b0, 7); run(3);
        clear_ctl(); plan(1'b0, 7); run(-1);
        chk("rerun_cnt15", 32'(cycle_count), 15);

        // Randomized programs, stalls and forward branches
        for (int r = 0; r < 8; r++) begin
            hpos = int'($urandom_range(20, 2));
            load_random(hpos);
            clear_ctl();
            plan(1'b1, hpos);
            run(-1);
        end

        // Counter saturation on the free-running instance
        while (ticks < t0 + 65534) tick();
        chk("w_cnt_fffe", 32'(cnt_w), 32'hFFFE);
        tick();
        chk("w_cnt_ffff", 32'(cnt_w), 32'hFFFF);
        repeat (5) tick();
        chk("w_cnt_sat", 32'(cnt_w), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
